// File: rtl/picoblaze_port_hub_pkg.sv
// Address map, error-bit positions and configuration limits for the PicoBlaze port hub.
// There is no logic here: only constants and pure helper functions.
package picoblaze_port_hub_pkg;

  localparam logic [7:0] IN_BASE   = 8'h00;
  localparam logic [7:0] OUT_BASE  = 8'h20;
  localparam logic [7:0] MBOX_BASE = 8'h40;
  localparam logic [7:0] MBOX_STAT = 8'h50;
  localparam logic [7:0] ERR_REG   = 8'h51;
  localparam logic [7:0] IRQ_PEND  = 8'h60;
  localparam logic [7:0] IRQ_MASK  = 8'h61;
  localparam logic [7:0] IRQ_CLR   = 8'h62;

  localparam int ERR_COLL  = 0;
  localparam int ERR_FULL  = 1;
  localparam int ERR_EMPTY = 2;

  function automatic logic [7:0] addr_of(logic [7:0] base, int idx);
    return base + 8'(idx);
  endfunction

  function automatic bit cfg_ok(int nc, int ni, int no, int nm, int nq);
    return (nc >= 1 && nc <= 4) && (ni >= 1 && ni <= 16) && (no >= 1 && no <= 16) &&
           (nm >= 1 && nm <= 8) && (nq >= 1 && nq <= 7);
  endfunction

endpackage

// File: rtl/picoblaze_port_hub_irq_ctrl.sv
// Per-core interrupt controller: rising-edge detect, sticky pending, mask and the interrupt flop.
// interrupt rises on the edge that sets a newly unmasked pending bit; it is held until acknowledged, with no backpressure.
module picoblaze_irq_ctrl
  import picoblaze_port_hub_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_IRQ-1:0] irq_src_i,
  input  logic               mbox_evt_i,
  input  logic               mask_we_i,
  input  logic               clr_we_i,
  input  logic [NUM_IRQ:0]   wdat_i,
  input  logic               ack_i,
  output logic [NUM_IRQ:0]   pend_o,
  output logic [NUM_IRQ:0]   mask_o,
  output logic               irq_o
);

  logic [NUM_IRQ-1:0] hist_q;
  logic [NUM_IRQ:0]   pend_q, pend_d, mask_q, mask_d, set_bits, clr_bits;
  logic               irq_q, irq_d, new_evt;

  always_comb begin
    set_bits = {mbox_evt_i, irq_src_i & ~hist_q};
    clr_bits = clr_we_i ? wdat_i : '0;
    // A set arriving in the same cycle as its clear leaves the bit pending.
    pend_d   = (pend_q & ~clr_bits) | set_bits;
    mask_d   = mask_we_i ? wdat_i : mask_q;
    new_evt  = |((pend_d & mask_d) & ~(pend_q & mask_q));
    irq_d    = (irq_q & ~ack_i) | new_evt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= '0;
      pend_q <= '0;
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      hist_q <= irq_src_i;
      pend_q <= pend_d;
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  assign pend_o = pend_q;
  assign mask_o = mask_q;
  assign irq_o  = irq_q;

endmodule

// File: rtl/picoblaze_port_hub.sv
// Per-core I/O decode, shared mailboxes with fixed-priority write arbitration, and a per-core IRQ block.
// Read data is registered one cycle after port_id; writes land on the strobe edge; there is no backpressure.
module picoblaze_port_hub
  import picoblaze_port_hub_pkg::*;
#(
  parameter int NUM_CORES = 2,
  parameter int NUM_IN    = 8,
  parameter int NUM_OUT   = 8,
  parameter int NUM_MBOX  = 4,
  parameter int NUM_IRQ   = 4
) (
  input  logic                          sysclk,
  input  logic                          sysreset,
  input  logic [NUM_CORES*8-1:0]        port_id,
  input  logic [NUM_CORES-1:0]          write_strobe,
  input  logic [NUM_CORES-1:0]          read_strobe,
  input  logic [NUM_CORES*8-1:0]        io_data_in,
  output logic [NUM_CORES*8-1:0]        io_data_out,
  output logic [NUM_CORES-1:0]          interrupt,
  input  logic [NUM_CORES-1:0]          interrupt_ack,
  input  logic [NUM_CORES*NUM_IRQ-1:0]  irq_src,
  input  logic [NUM_CORES*NUM_IN*8-1:0] in_ports,
  output logic [NUM_CORES*NUM_OUT*8-1:0] out_ports
);

  localparam int PW = NUM_IRQ + 1;

  if (!cfg_ok(NUM_CORES, NUM_IN, NUM_OUT, NUM_MBOX, NUM_IRQ)) begin : g_cfg_err
    $error("picoblaze_port_hub: parameter out of range");
  end

  logic [7:0]                    pid  [NUM_CORES];
  logic [7:0]                    wdat [NUM_CORES];
  logic [NUM_CORES*NUM_OUT*8-1:0] out_q, out_d;
  logic [7:0]                    mbox_q [NUM_MBOX];
  logic [7:0]                    mbox_d [NUM_MBOX];
  logic [NUM_MBOX-1:0]           full_q, full_d, taken;
  logic [2:0]                    err_q [NUM_CORES];
  logic [2:0]                    err_d [NUM_CORES];
  logic [NUM_CORES*8-1:0]        rdat_q, rdat_d;
  logic [NUM_CORES-1:0]          mbox_evt, mask_we, clr_we;
  logic [NUM_CORES*PW-1:0]       pend_w, mask_w;

  for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
    assign pid[c]  = port_id[c*8 +: 8];
    assign wdat[c] = io_data_in[c*8 +: 8];

    picoblaze_irq_ctrl #(.NUM_IRQ(NUM_IRQ)) u_irq (
      .clk_i      (sysclk),
      .rst_ni     (sysreset),
      .irq_src_i  (irq_src[c*NUM_IRQ +: NUM_IRQ]),
      .mbox_evt_i (mbox_evt[c]),
      .mask_we_i  (mask_we[c]),
      .clr_we_i   (clr_we[c]),
      .wdat_i     (io_data_in[c*8 +: PW]),
      .ack_i      (interrupt_ack[c]),
      .pend_o     (pend_w[c*PW +: PW]),
      .mask_o     (mask_w[c*PW +: PW]),
      .irq_o      (interrupt[c])
    );
  end

  // Read-strobe side effects are applied first so that same-cycle writes and errors win.
  always_comb begin
    out_d    = out_q;
    full_d   = full_q;
    taken    = '0;
    mbox_evt = '0;
    mask_we  = '0;
    clr_we   = '0;
    for (int m = 0; m < NUM_MBOX; m++) mbox_d[m] = mbox_q[m];
    for (int c = 0; c < NUM_CORES; c++) err_d[c] = err_q[c];

    for (int c = 0; c < NUM_CORES; c++) begin
      if (read_strobe[c]) begin
        if (pid[c] == ERR_REG) err_d[c] = '0;
        for (int m = 0; m < NUM_MBOX; m++) begin
          if (pid[c] == addr_of(MBOX_BASE, m)) begin
            if (!full_q[m]) err_d[c][ERR_EMPTY] = 1'b1;
            full_d[m] = 1'b0;
          end
        end
      end
      if (write_strobe[c]) begin
        for (int i = 0; i < NUM_OUT; i++) begin
          if (pid[c] == addr_of(OUT_BASE, i)) out_d[(c*NUM_OUT+i)*8 +: 8] = wdat[c];
        end
        mask_we[c] = (pid[c] == IRQ_MASK);
        clr_we[c]  = (pid[c] == IRQ_CLR);
      end
    end

    // Cores are scanned in index order, so the first requester of a mailbox owns it this cycle.
    for (int m = 0; m < NUM_MBOX; m++) begin
      for (int c = 0; c < NUM_CORES; c++) begin
        if (write_strobe[c] && pid[c] == addr_of(MBOX_BASE, m)) begin
          if (taken[m]) begin
            err_d[c][ERR_COLL] = 1'b1;
          end else begin
            taken[m]  = 1'b1;
            mbox_d[m] = wdat[c];
            if (full_q[m]) err_d[c][ERR_FULL] = 1'b1;
            full_d[m] = 1'b1;
            for (int k = 0; k < NUM_CORES; k++) begin
              if (k != c) mbox_evt[k] = 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    rdat_d = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (pid[c] == addr_of(IN_BASE, i)) rdat_d[c*8 +: 8] = in_ports[(c*NUM_IN+i)*8 +: 8];
      end
      for (int i = 0; i < NUM_OUT; i++) begin
        if (pid[c] == addr_of(OUT_BASE, i)) rdat_d[c*8 +: 8] = out_q[(c*NUM_OUT+i)*8 +: 8];
      end
      for (int m = 0; m < NUM_MBOX; m++) begin
        if (pid[c] == addr_of(MBOX_BASE, m)) rdat_d[c*8 +: 8] = mbox_q[m];
      end
      if (pid[c] == MBOX_STAT) rdat_d[c*8 +: NUM_MBOX] = full_q;
      if (pid[c] == ERR_REG)   rdat_d[c*8 +: 3]        = err_q[c];
      if (pid[c] == IRQ_PEND)  rdat_d[c*8 +: PW]       = pend_w[c*PW +: PW];
      if (pid[c] == IRQ_MASK)  rdat_d[c*8 +: PW]       = mask_w[c*PW +: PW];
    end
  end

  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      out_q  <= '0;
      full_q <= '0;
      rdat_q <= '0;
      for (int m = 0; m < NUM_MBOX; m++) mbox_q[m] <= '0;
      for (int c = 0; c < NUM_CORES; c++) err_q[c] <= '0;
    end else begin
      out_q  <= out_d;
      full_q <= full_d;
      rdat_q <= rdat_d;
      for (int m = 0; m < NUM_MBOX; m++) mbox_q[m] <= mbox_d[m];
      for (int c = 0; c < NUM_CORES; c++) err_q[c] <= err_d[c];
    end
  end

  assign io_data_out = rdat_q;
  assign out_ports   = out_q;

endmodule

// File: tb/tb_picoblaze_port_hub.sv
// Directed and randomized bench for picoblaze_port_hub against a transaction-level model of the address map.
module tb_picoblaze_port_hub;
  localparam int NC = 2, NI = 8, NO = 8, NM = 4, NQ = 4;

  logic                 sysclk = 1'b0;
  logic                 sysreset = 1'b1;
  logic [NC*8-1:0]      port_id, io_data_in, io_data_out;
  logic [NC-1:0]        write_strobe, read_strobe, interrupt, interrupt_ack;
  logic [NC*NQ-1:0]     irq_src;
  logic [NC*NI*8-1:0]   in_ports;
  logic [NC*NO*8-1:0]   out_ports;

  picoblaze_port_hub #(.NUM_CORES(NC), .NUM_IN(NI), .NUM_OUT(NO), .NUM_MBOX(NM), .NUM_IRQ(NQ)) dut (
    .sysclk(sysclk), .sysreset(sysreset), .port_id(port_id), .write_strobe(write_strobe),
    .read_strobe(read_strobe), .io_data_in(io_data_in), .io_data_out(io_data_out),
    .interrupt(interrupt), .interrupt_ack(interrupt_ack), .irq_src(irq_src),
    .in_ports(in_ports), .out_ports(out_ports)
  );

  always #5 sysclk = ~sysclk;

  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model state, expressed directly in terms of the visible registers.
  logic [7:0]  m_out [NC][NO];
  logic [7:0]  m_mbox [NM];
  bit          m_full [NM];
  logic [2:0]  m_err [NC];
  logic [NQ:0] m_pend [NC], m_mask [NC];
  bit          m_int [NC];
  logic [NQ-1:0] m_hist [NC];
  logic [7:0]  m_rd [NC];

  task automatic mdl_reset();
    for (int c = 0; c < NC; c++) begin
      for (int i = 0; i < NO; i++) m_out[c][i] = 8'h00;
      m_err[c] = '0; m_pend[c] = '0; m_mask[c] = '0; m_int[c] = 0; m_hist[c] = '0; m_rd[c] = 8'h00;
    end
    for (int m = 0; m < NM; m++) begin m_mbox[m] = 8'h00; m_full[m] = 0; end
  endtask

  function automatic logic [7:0] mdl_read(int c, int a);
    logic [7:0] v;
    v = 8'h00;
    if (a < NI) v = in_ports[(c*NI+a)*8 +: 8];
    else if (a >= 32 && a < 32+NO) v = m_out[c][a-32];
    else if (a >= 64 && a < 64+NM) v = m_mbox[a-64];
    else if (a == 80) begin for (int m = 0; m < NM; m++) v[m] = m_full[m]; end
    else if (a == 81) v = {5'd0, m_err[c]};
    else if (a == 96) v = {3'd0, m_pend[c]};
    else if (a == 97) v = {3'd0, m_mask[c]};
    return v;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic mdl_step();
    int a [NC];
    logic [7:0] d [NC];
    bit evt [NC];
    bit old_full [NM];
    int writers [$];
    logic [NQ:0] np, nm, clr;
    for (int c = 0; c < NC; c++) begin
      a[c] = int'(port_id[c*8 +: 8]); d[c] = io_data_in[c*8 +: 8]; evt[c] = 0;
      m_rd[c] = mdl_read(c, a[c]);
    end
    for (int m = 0; m < NM; m++) old_full[m] = m_full[m];
    for (int c = 0; c < NC; c++) begin
      if (read_strobe[c]) begin
        if (a[c] == 81) m_err[c] = '0;
        if (a[c] >= 64 && a[c] < 64+NM) begin
          if (!old_full[a[c]-64]) m_err[c][2] = 1'b1;
          m_full[a[c]-64] = 0;
        end
      end
      if (write_strobe[c] && a[c] >= 32 && a[c] < 32+NO) m_out[c][a[c]-32] = d[c];
    end
    for (int m = 0; m < NM; m++) begin
      writers = {};
      for (int c = 0; c < NC; c++) if (write_strobe[c] && a[c] == 64+m) writers.push_back(c);
      if (writers.size() > 0) begin
        m_mbox[m] = d[writers[0]];
        if (old_full[m]) m_err[writers[0]][1] = 1'b1;
        m_full[m] = 1;
        for (int k = 1; k < writers.size(); k++) m_err[writers[k]][0] = 1'b1;
        for (int c = 0; c < NC; c++) if (c != writers[0]) evt[c] = 1;
      end
    end
    for (int c = 0; c < NC; c++) begin
      clr = (write_strobe[c] && a[c] == 98) ? d[c][NQ:0] : '0;
      nm  = (write_strobe[c] && a[c] == 97) ? d[c][NQ:0] : m_mask[c];
      np  = (m_pend[c] & ~clr) | {evt[c], irq_src[c*NQ +: NQ] & ~m_hist[c]};
      m_int[c] = (m_int[c] && !interrupt_ack[c]) || (|((np & nm) & ~(m_pend[c] & m_mask[c])));
      m_pend[c] = np; m_mask[c] = nm; m_hist[c] = irq_src[c*NQ +: NQ];
    end
  endtask

  task automatic tick();
    mdl_step();
    @(posedge sysclk); #1;
    for (int c = 0; c < NC; c++) begin
      check($sformatf("rd_c%0d", c), 32'(io_data_out[c*8 +: 8]), 32'(m_rd[c]));
      check($sformatf("int_c%0d", c), 32'(interrupt[c]), 32'(m_int[c]));
      for (int i = 0; i < NO; i++)
        check($sformatf("out_c%0d_%0d", c, i), 32'(out_ports[(c*NO+i)*8 +: 8]), 32'(m_out[c][i]));
    end
  endtask

  task automatic idle();
    write_strobe = '0; read_strobe = '0; interrupt_ack = '0;
    port_id = {NC{8'h9F}}; io_data_in = '0;
  endtask

  task automatic drv(input int c, input logic [7:0] a, input logic [7:0] d, input bit wr, input bit rd);
    port_id[c*8 +: 8] = a; io_data_in[c*8 +: 8] = d; write_strobe[c] = wr; read_strobe[c] = rd;
  endtask

  task automatic wr(input int c, input logic [7:0] a, input logic [7:0] d);
    idle(); drv(c, a, d, 1, 0); tick(); idle();
  endtask

  task automatic rd(input int c, input logic [7:0] a, input bit rs, input logic [7:0] exp, input string tag);
    idle(); drv(c, a, 8'h00, 0, rs); tick(); idle();
    check(tag, 32'(io_data_out[c*8 +: 8]), 32'(exp));
  endtask

  task automatic do_reset();
    #1 sysreset = 1'b0;
    #1;
    check("rst_io_data_out", 32'(io_data_out), 32'h0);
    check("rst_interrupt", 32'(interrupt), 32'h0);
    check("rst_out_ports_lo", out_ports[31:0], 32'h0);
    check("rst_out_ports_any", 32'(|out_ports), 32'h0);
    mdl_reset();
    repeat (2) @(posedge sysclk);
    #1 sysreset = 1'b1;
  endtask

  logic [7:0] addrs [16] = '{8'h00, 8'h05, 8'h07, 8'h20, 8'h21, 8'h27, 8'h40, 8'h41,
                             8'h42, 8'h43, 8'h50, 8'h51, 8'h60, 8'h61, 8'h62, 8'h9F};

  initial begin
    idle();
    irq_src = '0;
    in_ports = {$urandom, $urandom, $urandom, $urandom};
    do_reset();
    repeat (2) tick();

    // Read mux and unmapped decode
    in_ports[(1*NI+5)*8 +: 8] = 8'h7E;
    check("in_not_early", 32'(io_data_out[15:8]), 32'h0);
    rd(1, 8'h05, 0, 8'h7E, "in_c1p5");
    rd(1, 8'h9F, 0, 8'h00, "unmapped");

    // Mailbox handoff
    wr(0, 8'h40, 8'h42);
    rd(1, 8'h50, 1, 8'h01, "mbox_full_set");
    rd(1, 8'h40, 1, 8'h42, "mbox_data");
    rd(1, 8'h50, 1, 8'h00, "mbox_full_clr");
    rd(1, 8'h60, 0, 8'h10, "mbox_pend_c1");
    rd(0, 8'h60, 0, 8'h00, "mbox_pend_c0");
    wr(1, 8'h62, 8'h10);

    // Collision on mailbox 1
    idle(); drv(0, 8'h41, 8'h11, 1, 0); drv(1, 8'h41, 8'h22, 1, 0); tick(); idle();
    rd(1, 8'h41, 1, 8'h11, "coll_winner");
    rd(1, 8'h51, 1, 8'h01, "coll_err");
    rd(1, 8'h51, 1, 8'h00, "coll_err_cleared");
    wr(1, 8'h62, 8'hFF);

    // Overflow and underflow
    wr(0, 8'h40, 8'h01);
    wr(0, 8'h40, 8'h02);
    rd(0, 8'h51, 1, 8'h02, "ovf_err");
    rd(0, 8'h43, 1, 8'h00, "empty_read");
    rd(0, 8'h51, 1, 8'h04, "unf_err");
    rd(0, 8'h40, 1, 8'h02, "ovf_data");

    // Interrupt closed loop
    wr(0, 8'h61, 8'h01);
    irq_src[0] = 1'b1; tick(); irq_src[0] = 1'b0;
    check("irq_raise", 32'(interrupt[0]), 32'h1);
    tick(); tick();
    check("irq_hold", 32'(interrupt[0]), 32'h1);
    interrupt_ack[0] = 1'b1; tick(); interrupt_ack[0] = 1'b0;
    check("irq_ack", 32'(interrupt[0]), 32'h0);
    wr(0, 8'h62, 8'h01);
    wr(0, 8'h61, 8'h03);
    irq_src[0] = 1'b1; tick(); irq_src[0] = 1'b0;
    check("irq_raise2", 32'(interrupt[0]), 32'h1);
    irq_src[1] = 1'b1; interrupt_ack[0] = 1'b1; tick(); interrupt_ack[0] = 1'b0; irq_src[1] = 1'b0;
    check("irq_ack_vs_edge", 32'(interrupt[0]), 32'h1);
    interrupt_ack[0] = 1'b1; tick(); interrupt_ack[0] = 1'b0;
    check("irq_ack2", 32'(interrupt[0]), 32'h0);
    wr(0, 8'h62, 8'h03);
    rd(0, 8'h60, 0, 8'h00, "pend_cleared");
    wr(0, 8'h61, 8'hFF);
    rd(0, 8'h61, 0, 8'h1F, "mask_width");

    // Reset mid-run
    wr(0, 8'h20, 8'hA5);
    wr(0, 8'h62, 8'hFF);
    wr(0, 8'h61, 8'h01);
    irq_src[0] = 1'b1; tick(); irq_src[0] = 1'b0;
    check("pre_rst_out", 32'(out_ports[7:0]), 32'hA5);
    check("pre_rst_int", 32'(interrupt[0]), 32'h1);
    do_reset();
    rd(0, 8'h20, 0, 8'h00, "post_rst_out");
    rd(0, 8'h50, 0, 8'h00, "post_rst_full");
    rd(0, 8'h61, 0, 8'h00, "post_rst_mask");

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      idle();
      for (int c = 0; c < NC; c++) begin
        logic [7:0] a;
        a = ($urandom_range(0, 7) == 0) ? 8'($urandom) : addrs[$urandom_range(0, 15)];
        drv(c, a, 8'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
        interrupt_ack[c] = ($urandom_range(0, 3) == 0);
      end
      irq_src = NC*NQ'($urandom);
      if (n % 40 == 0) in_ports = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end

    idle();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/picoblaze_port_hub.md
Name: picoblaze_port_hub

Overview:
- Parametrised I/O hub connecting NUM_CORES PicoBlaze (KCPSM6) cores to board and Rojobot ports through a uniform per-core address map.
- Adds shared mailboxes for inter-core messaging, with fixed-priority write arbitration and error flags.
- Adds a maskable multi-source interrupt controller per core.
- Sits between the PicoBlaze instances and the top-level board/bot glue, replacing hand-written per-core port muxes.

Parameters:
- NUM_CORES, 2, number of PicoBlaze cores (1..4)
- NUM_IN, 8, input ports per core (1..16)
- NUM_OUT, 8, output registers per core (1..16)
- NUM_MBOX, 4, shared 8-bit mailboxes (1..8)
- NUM_IRQ, 4, external interrupt sources per core (1..7)

Ports:
- sysclk  in  1  system clock
- sysreset  in  1  reset, asynchronous, active-low
- port_id  in  NUM_CORES*8  per-core port address (core c at [8c+7:8c]; same packing for all per-core buses)
- write_strobe  in  NUM_CORES  per-core write qualifier
- read_strobe  in  NUM_CORES  per-core read qualifier
- io_data_in  in  NUM_CORES*8  per-core write data
- io_data_out  out  NUM_CORES*8  per-core registered read data
- interrupt  out  NUM_CORES  per-core interrupt request
- interrupt_ack  in  NUM_CORES  per-core interrupt acknowledge
- irq_src  in  NUM_CORES*NUM_IRQ  external interrupt sources, level, synchronous to sysclk
- in_ports  in  NUM_CORES*NUM_IN*8  board/bot input bytes
- out_ports  out  NUM_CORES*NUM_OUT*8  board/bot output registers

Behaviour:
- Reset (sysreset=0, async): io_data_out=0, interrupt=0, out_ports=0, mailbox data=0, full flags=0, error regs=0, masks=0, pending=0, edge-detect history=0.
- Per-core address map, full 8-bit decode:
  - 0x00+i: in_ports i (read only).
  - 0x20+i: out register i (write; readable back).
  - 0x40+m: mailbox m (R/W, shared by all cores).
  - 0x50: mailbox full flags [NUM_MBOX-1:0] (read only).
  - 0x51: error reg (read, clear-on-read): bit0 = lost write collision, bit1 = wrote to full mailbox, bit2 = read of empty mailbox.
  - 0x60: pending (read). 0x61: mask (R/W). 0x62: write-1-to-clear pending.
  - Unmapped reads return 0x00. Unmapped writes are ignored.
- Read latency: io_data_out valid 1 cycle after port_id; port_id-decoded every cycle independent of read_strobe.
- read_strobe side effects occur in the strobe cycle: mailbox full clears, error reg clears.
- Writes take effect at the clock edge where write_strobe=1.
- Mailbox write arbitration: several cores writing the same mailbox in one cycle → lowest core index wins. Each loser gets error bit0 set; its data is dropped.
- Write to a full mailbox: data overwritten, full stays 1, writer's error bit1 set.
- Read + write of the same mailbox in one cycle: reader gets old data; full=1 afterwards (set beats clear).
- Pending register is NUM_IRQ+1 bits:
  - bits [NUM_IRQ-1:0] set on a rising edge of irq_src (1-cycle history register).
  - bit NUM_IRQ set when another core successfully writes any mailbox.
  - Pending is sticky until cleared via 0x62. A new edge in the same cycle as a clear of that bit → bit stays set.
- Interrupt, closed loop: new_event = any bit of (pending & mask) going 0→1, including via a mask write. interrupt_next = (interrupt & ~interrupt_ack) | new_event. Held until ack.
- Mask bits above NUM_IRQ read back as 0.

Decomposition:
- Shared package: address constants (IN_BASE 0x20-apart, OUT_BASE, MBOX_BASE, MBOX_STAT, ERR_REG, IRQ_PEND/IRQ_MASK/IRQ_CLR), error-bit indices, parameter range checks.
- Sub-module picoblaze_irq_ctrl: one per core via generate; holds edge detect, pending, mask and the interrupt flop.
- Mailbox arbitration and read mux stay in the top module.

Test Plan:
- Reset mid-run: out reg 0x20 = 0xA5 and interrupt=1 on core0, then assert sysreset=0 → all outputs 0 asynchronously; reads of 0x20, 0x50, 0x61 return 0x00.
- Mailbox handoff: core0 writes 0x42 → 0x40; core1 reads 0x50 = 0x01, then 0x40 = 0x42 one cycle later → 0x50 reads 0x00; core1 pending bit NUM_IRQ = 1.
- Collision: core0 writes 0x11 and core1 writes 0x22 to 0x41 in the same cycle → mailbox1 = 0x11; core1 0x51 = 0x01, second read of 0x51 = 0x00.
- Overflow/underflow: write 0x40 twice without a read → writer's 0x51 = 0x02. Read empty 0x43 → 0x51 = 0x04.
- Interrupt: mask = 0x01, pulse irq_src[0] → interrupt=1 next cycle, held until ack. Ack in the same cycle as an irq_src[1] edge with mask = 0x03 → interrupt stays 1. Write 0x62 = 0x03 → pending = 0.
- Read mux: in_ports core1 port 5 = 0x7E; port_id=0x05 → io_data_out core1 = 0x7E exactly one cycle later. port_id=0x9F (unmapped) → 0x00.
